// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: round-robin two-requester word serializer.
// A granted N-bit word is shifted out MSB first under a valid/ready
// handshake, followed by a one-cycle done pulse.
// Optional feature macro: SHIFT_SEQ_CTRL_PARITY_EN appends an even-parity
// bit (XOR of the loaded word) after the last data bit.
// Reset: clr, synchronous, active-low.
module shift_seq_ctrl #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         req_a,
  input  logic [N-1:0] data_a,
  input  logic         req_b,
  input  logic [N-1:0] data_b,
  output logic         gnt_a,
  output logic         gnt_b,
  output logic         ser_out,
  output logic         ser_valid,
  input  logic         ser_rdy,
  output logic         busy,
  output logic         done
);

  localparam int CW = $clog2(N + 1);

`ifdef SHIFT_SEQ_CTRL_PARITY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2, PAR = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;
`endif

  state_t          state;
  state_t          state_nxt;
  logic [N-1:0]    sreg;
  logic [CW-1:0]   cnt;
  logic            last_b;     // 1: B was served last, so A wins a tie
  logic            accept;
  logic            win_a;
  logic            last_bit;
`ifdef SHIFT_SEQ_CTRL_PARITY_EN
  logic            par_bit;
`endif

  assign win_a    = req_a && (!req_b || last_b);
  assign last_bit = (cnt == CW'(N - 1));

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!clr) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state decode plus state-derived outputs (no input-to-output paths).
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_nxt = state;
    accept    = 1'b0;
    busy      = (state != IDLE);
    done      = 1'b0;
    ser_valid = 1'b0;
    ser_out   = 1'b0;
    case (state)
      IDLE: begin
        if (req_a || req_b) begin
          accept    = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        ser_valid = 1'b1;
        ser_out   = sreg[N-1];
        if (ser_rdy && last_bit) begin
`ifdef SHIFT_SEQ_CTRL_PARITY_EN
          state_nxt = PAR;
`else
          state_nxt = DONE;
`endif
        end
      end
`ifdef SHIFT_SEQ_CTRL_PARITY_EN
      PAR: begin
        ser_valid = 1'b1;
        ser_out   = par_bit;
        if (ser_rdy) state_nxt = DONE;
      end
`endif
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: word load on accept, shift on each accepted bit, grant pulses.
  always_ff @(posedge clk) begin
    // NOTE: the shift register is cleared on reset so an aborted word can
    // never reappear on ser_out after reset is released.
    if (!clr) begin
      sreg   <= '0;
      cnt    <= '0;
      gnt_a  <= 1'b0;
      gnt_b  <= 1'b0;
      last_b <= 1'b1;
`ifdef SHIFT_SEQ_CTRL_PARITY_EN
      par_bit <= 1'b0;
`endif
    end else begin
      gnt_a <= 1'b0;
      gnt_b <= 1'b0;
      if (accept) begin
        sreg   <= win_a ? data_a : data_b;
        cnt    <= '0;
        gnt_a  <= win_a;
        gnt_b  <= !win_a;
        last_b <= !win_a;
`ifdef SHIFT_SEQ_CTRL_PARITY_EN
        par_bit <= win_a ? ^data_a : ^data_b;
`endif
      end else if (state == SHIFT && ser_rdy) begin
        sreg <= {sreg[N-2:0], 1'b0};
        cnt  <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// tb_shift_seq_ctrl: directed, table-driven bench for shift_seq_ctrl (N=4),
// with hand-written sequences for arbitration, reset abort and late requests.
module tb_shift_seq_ctrl;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         clr;
  logic         req_a, req_b, ser_rdy;
  logic [N-1:0] data_a, data_b;
  logic         gnt_a, gnt_b, ser_out, ser_valid, busy, done;

  int checks = 0;
  int errors = 0;

  shift_seq_ctrl #(.N(N)) dut (
    .clk(clk), .clr(clr),
    .req_a(req_a), .data_a(data_a),
    .req_b(req_b), .data_b(data_b),
    .gnt_a(gnt_a), .gnt_b(gnt_b),
    .ser_out(ser_out), .ser_valid(ser_valid), .ser_rdy(ser_rdy),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic         clr, ra, rb, rdy;
    logic [N-1:0] da, db;
    logic [5:0]   exp;    // {gnt_a, gnt_b, ser_out, ser_valid, busy, done}
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic c, input logic ra, input logic rb, input logic rdy,
                     input logic [N-1:0] da, input logic [N-1:0] db, input logic [5:0] exp);
    vec_t v;
    v.clr = c; v.ra = ra; v.rb = rb; v.rdy = rdy; v.da = da; v.db = db; v.exp = exp;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [5:0] outs();
    return {gnt_a, gnt_b, ser_out, ser_valid, busy, done};
  endfunction

  task automatic do_reset();
    clr = 1'b0; req_a = 1'b0; req_b = 1'b0; ser_rdy = 1'b1;
    data_a = '0; data_b = '0;
    tick();
    tick();
    clr = 1'b1;
  endtask

  // Wait for a grant, then collect and compare one full transfer (ser_rdy=1).
  task automatic run_xfer(input string name, input bit exp_a, input logic [N-1:0] word,
                          input bit drop);
    int n;
    logic [N-1:0] bits;
    n = 0;
    while (!gnt_a && !gnt_b && n < 20) begin
      tick();
      n++;
    end
    check({name, "_gnt_in_time"}, (n < 20), 1);
    check({name, "_gnt_a"}, gnt_a, exp_a);
    check({name, "_gnt_b"}, gnt_b, !exp_a);
    if (drop) begin
      req_a = 1'b0;
      req_b = 1'b0;
    end
    bits = '0;
    for (int i = 0; i < N; i++) begin
      check({name, "_valid"}, ser_valid, 1);
      bits = {bits[N-2:0], ser_out};
      tick();
    end
    check({name, "_word"}, bits, word);
`ifdef SHIFT_SEQ_CTRL_PARITY_EN
    check({name, "_par_valid"}, ser_valid, 1);
    check({name, "_par_bit"}, ser_out, ^word);
    tick();
`endif
    check({name, "_done"}, {done, ser_valid}, 2'b10);
    tick();
    check({name, "_idle"}, busy, 0);
  endtask

  initial begin
    int done_c, gb_c;
    logic saw_bad;

    // Trace A: 1011 with ser_rdy=1, then 1100 with a two-cycle stall.
    add(0, 0, 0, 1, 4'h0,    4'h0, 6'b000000); // reset
    add(1, 1, 0, 1, 4'b1011, 4'h0, 6'b101110); // cycle 1: gnt_a, bit 1
    add(1, 0, 0, 1, 4'h0,    4'h0, 6'b000110); // bit 0
    add(1, 0, 0, 1, 4'h0,    4'h0, 6'b001110); // bit 1
    add(1, 0, 0, 1, 4'h0,    4'h0, 6'b001110); // bit 1
`ifdef SHIFT_SEQ_CTRL_PARITY_EN
    add(1, 0, 0, 1, 4'h0,    4'h0, 6'b001110); // parity of 1011 = 1
`endif
    add(1, 0, 0, 1, 4'h0,    4'h0, 6'b000011); // done
    add(1, 0, 0, 1, 4'h0,    4'h0, 6'b000000); // idle
    add(1, 1, 0, 1, 4'b1100, 4'h0, 6'b101110); // cycle 1: gnt_a, bit 1
    add(1, 0, 0, 1, 4'h0,    4'h0, 6'b001110); // cycle 2: bit 1
    add(1, 0, 0, 0, 4'h0,    4'h0, 6'b001110); // stall holds bit 1
    add(1, 0, 0, 0, 4'h0,    4'h0, 6'b001110); // stall holds bit 1
    add(1, 0, 0, 1, 4'h0,    4'h0, 6'b000110); // bit 0
    add(1, 0, 0, 1, 4'h0,    4'h0, 6'b000110); // bit 0
`ifdef SHIFT_SEQ_CTRL_PARITY_EN
    add(1, 0, 0, 1, 4'h0,    4'h0, 6'b000110); // parity of 1100 = 0
`endif
    add(1, 0, 0, 1, 4'h0,    4'h0, 6'b000011); // done, two cycles late
    add(1, 0, 0, 1, 4'h0,    4'h0, 6'b000000); // idle

    clr = 1'b0; req_a = 1'b0; req_b = 1'b0; ser_rdy = 1'b1;
    data_a = '0; data_b = '0;
    #2;
    for (int i = 0; i < vecs.size(); i++) begin
      clr = vecs[i].clr; req_a = vecs[i].ra; req_b = vecs[i].rb;
      ser_rdy = vecs[i].rdy; data_a = vecs[i].da; data_b = vecs[i].db;
      tick();
      check($sformatf("vec%0d", i), outs(), vecs[i].exp);
    end

    // Round-robin with both requests held: A, B, A.
    do_reset();
    req_a = 1'b1; req_b = 1'b1; data_a = 4'hA; data_b = 4'h5;
    run_xfer("rr0", 1'b1, 4'hA, 1'b0);
    run_xfer("rr1", 1'b0, 4'h5, 1'b0);
    run_xfer("rr2", 1'b1, 4'hA, 1'b1);

    // Reset in cycle 2 of a transfer aborts it cleanly.
    do_reset();
    req_a = 1'b1; data_a = 4'b1011;
    tick();
    check("abort_gnt", gnt_a, 1);
    req_a = 1'b0;
    tick();
    clr = 1'b0;
    tick();
    check("abort_outs", outs(), 6'b000000);
    clr = 1'b1;
    saw_bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (ser_valid || done || busy) saw_bad = 1'b1;
    end
    check("abort_quiet", saw_bad, 0);
    req_a = 1'b1; data_a = 4'b0110;
    run_xfer("restart", 1'b1, 4'b0110, 1'b1);

    // req_b raised mid-transfer waits until after A's done.
    do_reset();
    req_a = 1'b1; data_a = 4'b0011;
    tick();                       // cycle 1
    check("late_gnt_a", gnt_a, 1);
    req_a = 1'b0;
    tick();                       // cycle 2
    req_b = 1'b1; data_b = 4'b1001;
    done_c = -1; gb_c = -1; saw_bad = 1'b0;
    for (int c = 3; c < 24; c++) begin
      tick();
      if (done && done_c < 0) done_c = c;
      if (gnt_b) begin
        gb_c = c;
        break;
      end
    end
    req_b = 1'b0;
`ifdef SHIFT_SEQ_CTRL_PARITY_EN
    check("late_done_cycle", done_c, 6);
`else
    check("late_done_cycle", done_c, 5);
`endif
    check("late_gnt_b_cycle", gb_c, done_c + 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
